// File: rtl/bcd_seq_monitor_pkg.sv
// Shared types and constants for the BCD sequence monitor.
// Successor helper used by the expected-value logic.
package bcd_seq_monitor_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [7:0] BCD2_SAT = 8'h99;

  function automatic logic [3:0] bcd_succ(
    input logic [3:0] v,
    input logic       up
  );
    logic [3:0] r;
    if (up) begin
      r = (v == BCD_MAX) ? 4'd0 : v + 4'd1;
    end else begin
      r = (v == 4'd0) ? BCD_MAX : v - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_seq_monitor_inc.sv
// Two-digit BCD tally that stops at 99.
// Units roll 9->0 and carry into tens.
module bcd2_sat_inc
  import bcd_seq_monitor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'h00;
    end else if (inc && cnt != BCD2_SAT) begin
      if (cnt[3:0] == BCD_MAX) begin
        cnt <= {cnt[7:4] + 4'd1, 4'd0};
      end else begin
        cnt <= {cnt[7:4], cnt[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/bcd_seq_monitor.sv
// Checks an up/down BCD counter stream for legal successors,
// tallies errors and wraps, and flags lock after LOCK_N matches.
module bcd_seq_monitor
  import bcd_seq_monitor_pkg::*;
#(
  parameter int unsigned LOCK_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m,
  input  logic [3:0] din,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [7:0] wrap_cnt
);

  localparam logic [3:0] LOCK = 4'(LOCK_N);

  state_t     state, state_nx;
  logic [3:0] prev, expd;
  logic [3:0] match_cnt, match_nx;
  logic       m_q;
  logic       vld, hit, bad, wrap;
  logic       locked_nx, load;

  assign vld  = din <= BCD_MAX;
  assign expd = bcd_succ(prev, m_q);
  assign hit  = (state == TRACK) && vld && (din == expd);
  assign bad  = !vld || ((state == TRACK) && !hit);
  assign load = (state == TRACK) || vld;

  // Wrap direction follows the mode that produced this sample.
  assign wrap = hit && (m_q
    ? (prev == BCD_MAX && din == 4'd0)
    : (prev == 4'd0 && din == BCD_MAX));

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SYNC:  if (vld)  state_nx = TRACK;
      TRACK: if (!vld) state_nx = SYNC;
      default:         state_nx = SYNC;
    endcase
  end

  always_comb begin
    match_nx  = match_cnt;
    locked_nx = locked;
    if (bad) begin
      match_nx  = 4'd0;
      locked_nx = 1'b0;
    end else if (hit) begin
      if (match_cnt != LOCK) match_nx = match_cnt + 4'd1;
      locked_nx = (match_nx == LOCK);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= 4'd0;
      m_q       <= 1'b0;
      match_cnt <= 4'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (load) begin
        prev <= din;
        m_q  <= m;
      end
      match_cnt <= match_nx;
      locked    <= locked_nx;
      err       <= bad;
    end
  end

  bcd2_sat_inc u_err (
    .clk   (clk),
    .reset (reset),
    .inc   (bad),
    .cnt   (err_cnt)
  );

  bcd2_sat_inc u_wrap (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap),
    .cnt   (wrap_cnt)
  );

endmodule

// File: tb/tb_bcd_seq_monitor.sv
// Directed and random stimulus for bcd_seq_monitor against
// an arithmetic model of the successor and tally rules.
module tb_bcd_seq_monitor;

  localparam int LN = 4;

  logic       clk;
  logic       reset;
  logic       m;
  logic [3:0] din;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  bit msync;
  int mprev;
  bit mmq;
  int mrun;
  bit mlock;
  bit merr;
  int nerr;
  int nwrap;

  bcd_seq_monitor #(.LOCK_N(LN)) dut (
    .clk      (clk),
    .reset    (reset),
    .m        (m),
    .din      (din),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .wrap_cnt (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    int s;
    s = (n > 99) ? 99 : n;
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp_v
  );
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    msync = 0; mprev = 0; mmq = 0; mrun = 0;
    mlock = 0; merr = 0; nerr = 0; nwrap = 0;
  endtask

  task automatic model_step(input int d, input bit mm);
    int e;
    merr = 0;
    if (!msync) begin
      if (d <= 9) begin
        msync = 1; mprev = d; mmq = mm;
      end else begin
        merr = 1; nerr++;
      end
    end else begin
      e = mmq ? (mprev + 1) % 10 : (mprev + 9) % 10;
      if (d > 9) begin
        merr = 1; nerr++; mrun = 0; mlock = 0; msync = 0;
      end else if (d != e) begin
        merr = 1; nerr++; mrun = 0; mlock = 0;
        mprev = d; mmq = mm;
      end else begin
        if (mrun < LN) mrun++;
        mlock = (mrun == LN);
        if (mmq ? (mprev == 9 && d == 0)
                : (mprev == 0 && d == 9)) nwrap++;
        mprev = d; mmq = mm;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".err"},    {7'd0, err},    {7'd0, merr});
    chk({tag, ".locked"}, {7'd0, locked}, {7'd0, mlock});
    chk({tag, ".errcnt"}, err_cnt,        to_bcd(nerr));
    chk({tag, ".wrap"},   wrap_cnt,       to_bcd(nwrap));
  endtask

  task automatic step(input int d, input bit mm);
    din = 4'(d);
    m   = mm;
    @(posedge clk);
    #1;
    model_step(d, mm);
    check_all("step");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst.err",    {7'd0, err},    8'h00);
    chk("rst.locked", {7'd0, locked}, 8'h00);
    chk("rst.errcnt", err_cnt,        8'h00);
    chk("rst.wrap",   wrap_cnt,       8'h00);
  endtask

  initial begin
    int d;
    reset = 1'b1;
    m     = 1'b0;
    din   = 4'd0;
    @(posedge clk);
    #1;

    // Up stream through one wrap.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(i % 10, 1'b1);
      if (i == 4) chk("t1.lock5", {7'd0, locked}, 8'h01);
    end
    chk("t1.wrap",   wrap_cnt, 8'h01);
    chk("t1.errcnt", err_cnt,  8'h00);

    // Up to 5, then count down through 0->9.
    do_reset();
    for (int i = 0; i <= 5; i++) step(i, 1'b1);
    chk("t2.locked", {7'd0, locked}, 8'h01);
    step(6, 1'b0);
    for (int v = 5; v >= 0; v--) step(v, 1'b0);
    step(9, 1'b0);
    step(8, 1'b0);
    chk("t2.wrap",   wrap_cnt, 8'h01);
    chk("t2.errcnt", err_cnt,  8'h00);

    // Single glitch then relock.
    do_reset();
    for (int i = 8; i <= 13; i++) step(i % 10, 1'b1);
    step(7, 1'b1);
    chk("t3.err",    {7'd0, err},    8'h01);
    chk("t3.drop",   {7'd0, locked}, 8'h00);
    chk("t3.errcnt", err_cnt,        8'h01);
    for (int i = 8; i <= 11; i++) step(i % 10, 1'b1);
    chk("t3.relock", {7'd0, locked}, 8'h01);

    // Invalid value forces resync.
    step(12, 1'b1);
    chk("t4.err", {7'd0, err}, 8'h01);
    step(3, 1'b1);
    chk("t4.noerr", {7'd0, err}, 8'h00);
    step(4, 1'b1);
    chk("t4.errcnt", err_cnt, 8'h02);

    // Saturating error tally.
    do_reset();
    for (int i = 0; i < 105; i++) step(15, 1'b0);
    chk("t5.sat", err_cnt, 8'h99);
    chk("t5.err", {7'd0, err}, 8'h01);

    // Reset while locked with nonzero tallies.
    do_reset();
    for (int i = 0; i < 3; i++) step(15, 1'b1);
    for (int i = 8; i <= 20; i++) step(i % 10, 1'b1);
    chk("t6.errcnt", err_cnt,        8'h03);
    chk("t6.wrap",   wrap_cnt,       8'h02);
    chk("t6.locked", {7'd0, locked}, 8'h01);
    do_reset();

    // Random stream: mostly legal, occasional glitches and mode flips.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(9) == 0) m = ~m;
      if (msync && $urandom_range(99) < 85) begin
        d = mmq ? (mprev + 1) % 10 : (mprev + 9) % 10;
      end else begin
        d = int'($urandom_range(15));
      end
      step(d, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
